cam_capture_gray: RTL and testbench

//  Camera capture front end that feeds the 8-bit frame-buffer BRAM directly.

---
 rtl/cam_capture_gray.sv | 144 ++++++++++++++
 tb/tb_cam_capture_gray.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_gray.sv
// cam_capture_gray: samples an RGB565 camera byte stream and writes 8-bit luma frames to BRAM in raster order
module cam_capture_gray #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              capture_en_i,
  input  logic              cam_pclk_en_i,
  input  logic              cam_vsync_i,
  input  logic              cam_href_i,
  input  logic [7:0]        cam_data_i,
  output logic              bram_en_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [7:0]        bram_din_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              short_frame_o,
  output logic [15:0]       frame_cnt_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int LW = $clog2(HEIGHT + 1);
  localparam logic [CW-1:0] W_C = CW'(WIDTH);
  localparam logic [LW-1:0] H_C = LW'(HEIGHT);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(WIDTH);
  typedef enum logic [1:0] {WAIT_VS, WAIT_FRAME, CAPTURE} state_t;
  state_t state_q, state_d;
  logic vs_prev_q, vs_prev_d, hr_prev_q, hr_prev_d, phase_q, phase_d;
  logic [7:0] hi_q, hi_d, din_q, din_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] line_q, line_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic we_q, we_d, done_q, done_d, short_q, short_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] pix, y_sum;
  logic [7:0] r8, g8, b8;
  assign pix   = {hi_q, cam_data_i};
  assign r8    = {pix[15:11], pix[15:13]};
  assign g8    = {pix[10:5], pix[10:9]};
  assign b8    = {pix[4:0], pix[4:2]};
  assign y_sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
  // Next state: frame sync FSM, pixel assembly, line bookkeeping and one-cycle write/done strobes
  always_comb begin
    state_d   = state_q;
    vs_prev_d = vs_prev_q;
    hr_prev_d = hr_prev_q;
    phase_d   = phase_q;
    hi_d      = hi_q;
    col_d     = col_q;
    line_d    = line_q;
    base_d    = base_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    done_d    = 1'b0;
    short_d   = short_q;
    cnt_d     = cnt_q;
    if (cam_pclk_en_i) begin
      vs_prev_d = cam_vsync_i;
      hr_prev_d = cam_href_i;
      case (state_q)
        WAIT_VS: state_d = cam_vsync_i ? WAIT_FRAME : WAIT_VS;
        WAIT_FRAME: begin
          if (vs_prev_q && !cam_vsync_i && capture_en_i) begin
            state_d = CAPTURE;
            line_d  = '0;
            base_d  = '0;
            col_d   = '0;
            phase_d = 1'b0;
          end
        end
        CAPTURE: begin
          if (!vs_prev_q && cam_vsync_i) begin
            state_d = WAIT_FRAME;
            done_d  = 1'b1;
            short_d = line_q < H_C;
            cnt_d   = cnt_q + 16'd1;
          end else if (cam_href_i) begin
            phase_d = !phase_q;
            if (!phase_q) hi_d = cam_data_i;
            else if (col_q < W_C && line_q < H_C) begin
              we_d   = 1'b1;
              addr_d = base_q + ADDR_W'(col_q);
              din_d  = 8'(y_sum >> 8);
              col_d  = col_q + 1'b1;
            end
          end else if (hr_prev_q) begin
            if (col_q != '0) begin
              line_d = line_q < H_C ? line_q + 1'b1 : line_q;
              base_d = base_q + W_A;
            end
            col_d   = '0;
            phase_d = 1'b0;
          end
        end
        default: state_d = WAIT_VS;
      endcase
    end
  end
  // State register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= WAIT_VS;
      vs_prev_q <= 1'b0;
      hr_prev_q <= 1'b0;
      phase_q   <= 1'b0;
      hi_q      <= '0;
      col_q     <= '0;
      line_q    <= '0;
      base_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      vs_prev_q <= vs_prev_d;
      hr_prev_q <= hr_prev_d;
      phase_q   <= phase_d;
      hi_q      <= hi_d;
      col_q     <= col_d;
      line_q    <= line_d;
      base_q    <= base_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      done_q    <= done_d;
      short_q   <= short_d;
      cnt_q     <= cnt_d;
    end
  end
  assign bram_en_o     = we_q;
  assign bram_we_o     = we_q;
  assign bram_addr_o   = addr_q;
  assign bram_din_o    = din_q;
  assign busy_o        = state_q == CAPTURE;
  assign frame_done_o  = done_q;
  assign short_frame_o = short_q;
  assign frame_cnt_o   = cnt_q;
endmodule

// File: tb/tb_cam_capture_gray.sv
// tb_cam_capture_gray: randomized frame stimulus checked against a frame-level write/done model
module tb_cam_capture_gray;
  localparam int W = 4, H = 2, AW = 3;
  logic clk = 0, rst_n = 0, cap = 0, pe = 0, vs = 0, hr = 0;
  logic [7:0] d = 0;
  logic en, we, busy, done, short_f;
  logic [AW-1:0] addr;
  logic [7:0] din;
  logic [15:0] fcnt;
  cam_capture_gray #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .capture_en_i(cap), .cam_pclk_en_i(pe),
    .cam_vsync_i(vs), .cam_href_i(hr), .cam_data_i(d),
    .bram_en_o(en), .bram_we_o(we), .bram_addr_o(addr), .bram_din_o(din),
    .busy_o(busy), .frame_done_o(done), .short_frame_o(short_f), .frame_cnt_o(fcnt)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, wr_seen = 0, cnt_exp = 0;
  int wq_a[$], wq_d[$], dq_c[$], lines_q[$], pix_src[$];
  bit dq_s[$];
  bit armed = 0, prev_cap = 0, prev_short = 0, hr_open = 0, jit = 0;
  function automatic void check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction
  function automatic int luma(int p);
    int r, g, b;
    r = (p >> 11) & 31;
    g = (p >> 5) & 63;
    b = p & 31;
    r = (r << 3) | (r >> 2);
    g = (g << 2) | (g >> 4);
    b = (b << 3) | (b >> 2);
    return ((77 * r + 150 * g + 29 * b) & 'hFFFF) >> 8;
  endfunction
  always @(negedge clk) begin
    check("en_eq_we", int'(en), int'(we));
    if (we) begin
      wr_seen++;
      if (wq_a.size() == 0) check("unexpected_write", int'(we), 0);
      else begin
        check("wr_addr", int'(addr), wq_a.pop_front());
        check("wr_din", int'(din), wq_d.pop_front());
      end
    end
    if (done) begin
      if (dq_s.size() == 0) check("unexpected_done", int'(done), 0);
      else begin
        check("short_frame", int'(short_f), int'(dq_s.pop_front()));
        check("frame_cnt_at_done", int'(fcnt), dq_c.pop_front());
      end
    end
  end
  task automatic strobe(bit v, bit h, logic [7:0] b);
    pe = 1; vs = v; hr = h; d = b;
    @(posedge clk); #1;
    pe = 0;
    repeat ($urandom_range(0, 2)) begin
      vs = 1'($urandom); hr = 1'($urandom); d = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask
  task automatic vs_high(int n);
    if (prev_cap) begin
      cnt_exp = (cnt_exp + 1) & 'hFFFF;
      dq_s.push_back(prev_short);
      dq_c.push_back(cnt_exp);
    end
    prev_cap = 0;
    for (int i = 0; i < n; i++) strobe(1, i == 0 && hr_open, 8'($urandom));
    hr_open = 0;
    armed = 1;
  endtask
  task automatic frame_lines(bit c, bit end_href);
    bit capd, last_open;
    int li, px;
    cap = c;
    strobe(0, 0, 8'($urandom));
    strobe(0, 0, 8'($urandom));
    capd = armed && c;
    li = 0;
    for (int l = 0; l < lines_q.size(); l++) begin
      last_open = end_href && l == lines_q.size() - 1;
      for (int p = 0; p < (lines_q[l] + 1) / 2; p++) begin
        px = pix_src.size() != 0 ? pix_src.pop_front() : int'($urandom_range(0, 65535));
        if (jit && $urandom_range(0, 7) == 0) cap = !cap;
        strobe(0, 1, 8'(px >> 8));
        if (2 * p + 1 < lines_q[l]) begin
          if (capd && p < W && li < H) begin
            wq_a.push_back(li * W + p);
            wq_d.push_back(luma(px));
          end
          strobe(0, 1, 8'(px));
        end
      end
      if (!last_open) begin
        if (capd && lines_q[l] >= 2 && li < H) li++;
        strobe(0, 0, 8'($urandom));
      end
    end
    hr_open = end_href;
    prev_cap = capd;
    prev_short = li < H;
    check("busy", int'(busy), int'(capd));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", int'(we), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(fcnt), 0);
    rst_n = 1;
    check("luma_FFFF", luma('hFFFF), 255);
    check("luma_0000", luma('h0000), 0);
    check("luma_F800", luma('hF800), 76);
    check("luma_07E0", luma('h07E0), 149);
    check("luma_001F", luma('h001F), 28);
    lines_q = {8, 8};
    frame_lines(1, 0);
    wr_seen = 0;
    pix_src = {'hFFFF, 'h0000, 'hF800, 'h07E0, 'h001F};
    vs_high(3);
    frame_lines(1, 0);
    vs_high(2);
    check("A_writes", wr_seen, 8);
    check("A_cnt", int'(fcnt), 1);
    check("A_short", int'(short_f), 0);
    wr_seen = 0;
    lines_q = {12, 8};
    frame_lines(1, 0);
    vs_high(2);
    check("B_writes", wr_seen, 8);
    wr_seen = 0;
    lines_q = {7, 8};
    frame_lines(1, 0);
    vs_high(2);
    check("C_writes", wr_seen, 7);
    wr_seen = 0;
    lines_q = {8, 8};
    frame_lines(0, 0);
    vs_high(2);
    check("D_writes", wr_seen, 0);
    check("D_cnt", int'(fcnt), 3);
    frame_lines(1, 0);
    vs_high(2);
    check("E_cnt", int'(fcnt), 4);
    lines_q = {8};
    frame_lines(1, 0);
    vs_high(2);
    check("F_short", int'(short_f), 1);
    check("F_cnt", int'(fcnt), 5);
    lines_q = {6};
    frame_lines(1, 1);
    repeat (3) @(posedge clk);
    #1;
    check("G_drained", wq_a.size(), 0);
    rst_n = 0;
    @(posedge clk); #1;
    check("G_rst_en", int'(en), 0);
    check("G_rst_we", int'(we), 0);
    check("G_rst_addr", int'(addr), 0);
    check("G_rst_din", int'(din), 0);
    check("G_rst_busy", int'(busy), 0);
    check("G_rst_done", int'(done), 0);
    check("G_rst_short", int'(short_f), 0);
    check("G_rst_cnt", int'(fcnt), 0);
    rst_n = 1;
    armed = 0; prev_cap = 0; cnt_exp = 0;
    lines_q = {8, 8};
    frame_lines(1, 0);
    jit = 1;
    repeat (30) begin
      vs_high($urandom_range(1, 3));
      lines_q.delete();
      repeat ($urandom_range(0, 4)) lines_q.push_back($urandom_range(0, 11));
      frame_lines($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end
    vs_high(2);
    repeat (4) @(posedge clk);
    #1;
    check("final_writes_pending", wq_a.size(), 0);
    check("final_done_pending", dq_s.size(), 0);
    check("final_cnt", int'(fcnt), cnt_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
